// File: rtl/dmem_access_arbiter.sv
// Shares the single-port data memory between the MEM stage and the UART debug
// channel; routes instruction-memory debug accesses to the imem debug port.
module dmem_access_arbiter #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned DADDR_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req_valid,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_stall,
    input  logic               cpu_halt,
    input  logic               dbg_req_valid,
    output logic               dbg_req_ready,
    input  logic               dbg_rw,
    input  logic               dbg_mem_type,
    input  logic [DADDR_W-1:0] dbg_addr,
    input  logic [31:0]        dbg_wdata,
    output logic               dbg_resp_valid,
    input  logic               dbg_resp_ready,
    output logic [41:0]        dbg_resp_frame,
    output logic               mem_we,
    output logic               mem_re,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic               imem_dbg_we,
    output logic [DADDR_W-1:0] imem_dbg_addr,
    output logic [31:0]        imem_dbg_wdata,
    input  logic [31:0]        imem_dbg_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_wait_cnt, w_wait_cnt_nxt;
    logic                 r_rw, r_type;
    logic [DADDR_W-1:0]   r_addr;
    logic [31:0]          r_wdata;
    logic [41:0]          r_frame, w_frame_nxt;
    logic                 w_latch;
    logic                 w_dgrant;
    logic [8:0]           w_faddr;

    assign w_faddr = 9'(r_addr);

    // Grant kept apart from the FSM block: mem_rdata depends on mem_addr, which depends on it.
    assign w_dgrant = !reset && (r_state == S_ARB) && !r_type &&
                      (!cpu_req_valid || cpu_halt || (r_wait_cnt == LP_MAX_WAIT));

    always_comb begin
        if (w_dgrant) begin
            mem_we    = r_rw;
            mem_re    = !r_rw;
            mem_addr  = 32'({r_addr, 2'b00});
            mem_wdata = r_wdata;
            cpu_rdata = '0;
        end else begin
            mem_we    = cpu_req_valid & cpu_we;
            mem_re    = cpu_req_valid & !cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end
    end

    assign cpu_stall      = w_dgrant & cpu_req_valid;
    assign imem_dbg_addr  = r_addr;
    assign imem_dbg_wdata = r_wdata;
    assign dbg_resp_frame = r_frame;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_frame_nxt    = r_frame;
        w_latch        = 1'b0;
        dbg_req_ready  = 1'b0;
        dbg_resp_valid = 1'b0;
        imem_dbg_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                dbg_req_ready = 1'b1;
                if (dbg_req_valid) begin
                    w_latch        = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_ARB;
                end
            end
            S_ARB: begin
                if (!r_type) begin
                    if (w_dgrant) begin
                        if (r_rw) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_frame_nxt = {1'b0, w_faddr, mem_rdata};
                            w_state_nxt = S_RESP;
                        end
                    end else if (r_wait_cnt != '1) begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end else if (cpu_halt) begin
                    if (r_rw) begin
                        imem_dbg_we = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_nxt = {1'b0, w_faddr, imem_dbg_rdata};
                        w_state_nxt = S_RESP;
                    end
                end else begin
                    w_frame_nxt = {1'b1, w_faddr, 32'h0};
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                dbg_resp_valid = 1'b1;
                if (dbg_resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Reset silences every debug-side output in the cycle it is asserted.
        if (reset) begin
            dbg_req_ready  = 1'b0;
            dbg_resp_valid = 1'b0;
            imem_dbg_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_rw       <= 1'b0;
            r_type     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_frame    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_frame    <= w_frame_nxt;
            if (w_latch) begin
                r_rw    <= dbg_rw;
                r_type  <= dbg_mem_type;
                r_addr  <= dbg_addr;
                r_wdata <= dbg_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: directed vector table, multi-cycle sequences and
// random traffic checked every cycle against a transaction-level model.
module tb_dmem_access_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int DADDR_W  = 9;

    logic               clk;
    logic               reset;
    logic               cpu_req_valid, cpu_we, cpu_halt;
    logic [31:0]        cpu_addr, cpu_wdata, cpu_rdata;
    logic               cpu_stall;
    logic               dbg_req_valid, dbg_req_ready, dbg_rw, dbg_mem_type;
    logic [DADDR_W-1:0] dbg_addr;
    logic [31:0]        dbg_wdata;
    logic               dbg_resp_valid, dbg_resp_ready;
    logic [41:0]        dbg_resp_frame;
    logic               mem_we, mem_re;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;
    logic               imem_dbg_we;
    logic [DADDR_W-1:0] imem_dbg_addr;
    logic [31:0]        imem_dbg_wdata, imem_dbg_rdata;

    dmem_access_arbiter #(.MAX_WAIT(MAX_WAIT), .DADDR_W(DADDR_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cpu_halt(cpu_halt),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_rw(dbg_rw),
        .dbg_mem_type(dbg_mem_type), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready),
        .dbg_resp_frame(dbg_resp_frame),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .imem_dbg_we(imem_dbg_we), .imem_dbg_addr(imem_dbg_addr),
        .imem_dbg_wdata(imem_dbg_wdata), .imem_dbg_rdata(imem_dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memories driven by the DUT's memory-side outputs.
    logic [31:0] env_dmem [512];
    logic [31:0] env_imem [512];
    assign mem_rdata      = env_dmem[mem_addr[10:2]];
    assign imem_dbg_rdata = env_imem[imem_dbg_addr];
    always @(posedge clk) begin
        if (mem_we)      env_dmem[mem_addr[10:2]] <= mem_wdata;
        if (imem_dbg_we) env_imem[imem_dbg_addr]  <= imem_dbg_wdata;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one pending request, a response queue, shadow memories.
    logic [31:0] sh_dmem [512];
    logic [31:0] sh_imem [512];
    logic        m_have = 1'b0;
    logic        m_rw = 1'b0, m_type = 1'b0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    int          m_waited = 0;
    logic [41:0] m_resp [$];
    logic        m_last_ready = 1'b0;
    logic        m_last_stall = 1'b0;

    logic        s_ready, s_stall, s_we, s_re, s_rv, s_iwe;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [41:0] s_frame;

    function automatic logic [31:0] pat(input int i, input logic [15:0] tag);
        return {tag ^ 16'(i), 16'(i * 37)};
    endfunction

    task automatic cycle();
        logic e_ready, e_dg, e_stall, e_we, e_re, e_iwe, e_rv, push, done;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [41:0] nf;
        #4;
        s_ready = dbg_req_ready; s_stall = cpu_stall; s_we = mem_we; s_re = mem_re;
        s_addr = mem_addr; s_wdata = mem_wdata; s_rdata = cpu_rdata;
        s_rv = dbg_resp_valid; s_frame = dbg_resp_frame; s_iwe = imem_dbg_we;

        e_ready = !reset && !m_have && (m_resp.size() == 0);
        e_dg    = !reset && m_have && !m_type &&
                  (!cpu_req_valid || cpu_halt || m_waited >= MAX_WAIT);
        e_stall = e_dg && cpu_req_valid;
        if (e_dg) begin
            e_we = m_rw; e_re = !m_rw; e_addr = {21'h0, m_addr, 2'b00};
            e_wdata = m_wdata; e_rdata = '0;
        end else begin
            e_we = cpu_req_valid && cpu_we; e_re = cpu_req_valid && !cpu_we;
            e_addr = cpu_addr; e_wdata = cpu_wdata; e_rdata = sh_dmem[cpu_addr[10:2]];
        end
        e_iwe = !reset && m_have && m_type && cpu_halt && m_rw;
        e_rv  = !reset && (m_resp.size() != 0);

        chk("ready", s_ready, e_ready);
        chk("stall", s_stall, e_stall);
        chk("mem_we", s_we, e_we);
        chk("mem_re", s_re, e_re);
        chk("mem_addr", s_addr, e_addr);
        chk("mem_wdata", s_wdata, e_wdata);
        chk("cpu_rdata", s_rdata, e_rdata);
        chk("imem_we", s_iwe, e_iwe);
        chk("resp_valid", s_rv, e_rv);
        if (e_rv) chk("resp_frame", s_frame, m_resp[0]);
        if (e_iwe) begin
            chk("imem_addr", imem_dbg_addr, m_addr);
            chk("imem_wdata", imem_dbg_wdata, m_wdata);
        end

        push = 1'b0; done = 1'b0; nf = '0;
        if (!reset && m_have) begin
            if (!m_type) begin
                if (e_dg) begin
                    done = 1'b1;
                    if (!m_rw) begin nf = {1'b0, m_addr, sh_dmem[m_addr]}; push = 1'b1; end
                end else begin
                    m_waited++;
                end
            end else begin
                done = 1'b1;
                push = !(cpu_halt && m_rw);
                if (!cpu_halt)  nf = {1'b1, m_addr, 32'h0};
                else if (!m_rw) nf = {1'b0, m_addr, sh_imem[m_addr]};
            end
        end
        if (e_we)  sh_dmem[e_addr[10:2]] = e_wdata;
        if (e_iwe) sh_imem[m_addr] = m_wdata;
        if (reset) begin
            m_have = 1'b0; m_waited = 0; m_resp.delete();
        end else begin
            if (m_resp.size() != 0 && dbg_resp_ready) void'(m_resp.pop_front());
            if (done) m_have = 1'b0;
            if (push) m_resp.push_back(nf);
            if (e_ready && dbg_req_valid) begin
                m_have = 1'b1; m_rw = dbg_rw; m_type = dbg_mem_type;
                m_addr = dbg_addr; m_wdata = dbg_wdata; m_waited = 0;
            end
        end
        m_last_ready = e_ready;
        m_last_stall = e_stall;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst, creq, cwe, halt, dval, drw, dtype;
        logic [8:0] daddr; logic [31:0] dwd; logic rrdy;
        logic e_ready, e_stall, e_we, e_re; logic [31:0] e_addr;
        logic e_rv; logic [41:0] e_frame; logic e_iwe;
    } vec_t;

    function automatic vec_t mk(input logic rst, creq, cwe, halt, dval, drw, dtype,
                                input logic [8:0] daddr, input logic [31:0] dwd, input logic rrdy,
                                input logic e_ready, e_stall, e_we, e_re,
                                input logic [31:0] e_addr, input logic e_rv,
                                input logic [41:0] e_frame, input logic e_iwe);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.halt = halt; v.dval = dval; v.drw = drw;
        v.dtype = dtype; v.daddr = daddr; v.dwd = dwd; v.rrdy = rrdy;
        v.e_ready = e_ready; v.e_stall = e_stall; v.e_we = e_we; v.e_re = e_re;
        v.e_addr = e_addr; v.e_rv = e_rv; v.e_frame = e_frame; v.e_iwe = e_iwe;
        return v;
    endfunction

    task automatic seq_forced(input bit use_halt, input int halt_at);
        int pass; bit seen; logic [31:0] ha, hd;
        cpu_halt = 0; dbg_resp_ready = 0;
        cpu_req_valid = 1; cpu_we = 1; cpu_addr = $urandom; cpu_wdata = $urandom;
        dbg_req_valid = 1; dbg_rw = 0; dbg_mem_type = 0; dbg_addr = 9'h003; dbg_wdata = '0;
        cycle();
        chk("fg_accept", s_ready, 1);
        dbg_req_valid = 0; pass = 0; seen = 0; ha = '0; hd = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (use_halt && k == halt_at) cpu_halt = 1;
            ha = cpu_addr; hd = cpu_wdata;
            cycle();
            if (s_stall) seen = 1;
            else begin pass++; cpu_addr = $urandom; cpu_wdata = $urandom; end
        end
        chk("fg_wait_cycles", pass, use_halt ? halt_at : MAX_WAIT);
        chk("fg_grant_re", s_re, 1);
        chk("fg_grant_we", s_we, 0);
        chk("fg_grant_addr", s_addr, 32'h0000_000C);
        dbg_resp_ready = 1;
        cycle();
        chk("fg_replay_we", s_we, 1);
        chk("fg_replay_addr", s_addr, ha);
        chk("fg_replay_data", s_wdata, hd);
        chk("fg_single_stall", s_stall, 0);
        chk("fg_resp_valid", s_rv, 1);
        cpu_req_valid = 0; cpu_halt = 0; dbg_resp_ready = 0;
        cycle();
    endtask

    task automatic seq_resp_hold();
        logic [41:0] ef;
        cpu_req_valid = 0; dbg_resp_ready = 0;
        dbg_req_valid = 1; dbg_rw = 0; dbg_mem_type = 0; dbg_addr = 9'h0AB;
        cycle();
        chk("rh_accept", s_ready, 1);
        dbg_rw = 1; dbg_addr = 9'h0CD; dbg_wdata = 32'h1234_5678;
        cycle();
        chk("rh_arb_ready", s_ready, 0);
        ef = {1'b0, 9'h0AB, sh_dmem[9'h0AB]};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rh_hold_valid", s_rv, 1);
            chk("rh_hold_frame", s_frame, ef);
            chk("rh_hold_ready", s_ready, 0);
        end
        dbg_resp_ready = 1;
        cycle();
        chk("rh_consume_ready", s_ready, 0);
        dbg_resp_ready = 0;
        cycle();
        chk("rh_accept_after", s_ready, 1);
        dbg_req_valid = 0;
        cycle();
        chk("rh_write_we", s_we, 1);
        chk("rh_write_addr", s_addr, 32'h0000_0334);
        cycle();
    endtask

    task automatic seq_reset();
        cpu_req_valid = 1; cpu_we = 0; cpu_addr = 32'h40; dbg_resp_ready = 0;
        dbg_req_valid = 1; dbg_rw = 1; dbg_mem_type = 0; dbg_addr = 9'h077; dbg_wdata = 32'hA5A5_5A5A;
        cycle();
        dbg_req_valid = 0; cpu_req_valid = 0; reset = 1;
        cycle();
        chk("rst_arb_we", s_we, 0);
        reset = 0;
        cycle();
        chk("rst_arb_idle", s_ready, 1);
        chk("rst_arb_we2", s_we, 0);
        chk("rst_arb_rv", s_rv, 0);
        dbg_req_valid = 1; dbg_rw = 0; dbg_addr = 9'h033;
        cycle();
        dbg_req_valid = 0;
        cycle();
        cycle();
        chk("rst_resp_pre", s_rv, 1);
        reset = 1;
        cycle();
        chk("rst_resp_rv", s_rv, 0);
        reset = 0;
        cycle();
        chk("rst_resp_rv2", s_rv, 0);
        chk("rst_resp_idle", s_ready, 1);
    endtask

    initial begin
        vec_t tbl [17];
        bit hold_dbg;
        for (int i = 0; i < 512; i++) begin
            env_dmem[i] = pat(i, 16'hC0DE); sh_dmem[i] = pat(i, 16'hC0DE);
            env_imem[i] = pat(i, 16'h1AAA); sh_imem[i] = pat(i, 16'h1AAA);
        end
        reset = 1; cpu_req_valid = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_halt = 0;
        dbg_req_valid = 0; dbg_rw = 0; dbg_mem_type = 0; dbg_addr = '0; dbg_wdata = '0;
        dbg_resp_ready = 0;

        //            rst creq cwe hlt dval drw typ addr    wdata         rrdy rdy stl we re addr      rv frame                               iwe
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        0,   0, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, 9'h005, 32'hDEADBEEF, 0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        0,   0, 0, 1, 0, 32'h14, 0, 42'h0,                              0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 9'h005, 32'h0,        0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        0,   0, 0, 0, 1, 32'h14, 0, 42'h0,                              0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        1,   0, 0, 0, 0, 32'h00, 1, {1'b0, 9'h005, 32'hDEADBEEF},       0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 1, 9'h010, 32'h13,       0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        0,   0, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        1,   0, 0, 0, 0, 32'h00, 1, {1'b1, 9'h010, 32'h0},              0);
        tbl[10] = mk(0, 0, 0, 1, 1, 1, 1, 9'h010, 32'h13,       0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 9'h000, 32'h0,        0,   0, 0, 0, 0, 32'h00, 0, 42'h0,                              1);
        tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 9'h000, 32'h0,        0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[13] = mk(0, 0, 0, 1, 1, 0, 1, 9'h010, 32'h0,        0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[14] = mk(0, 0, 0, 1, 0, 0, 0, 9'h000, 32'h0,        0,   0, 0, 0, 0, 32'h00, 0, 42'h0,                              0);
        tbl[15] = mk(0, 0, 0, 1, 0, 0, 0, 9'h000, 32'h0,        1,   0, 0, 0, 0, 32'h00, 1, {1'b0, 9'h010, 32'h13},             0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 9'h000, 32'h0,        0,   1, 0, 0, 0, 32'h00, 0, 42'h0,                              0);

        for (int i = 0; i < 17; i++) begin
            reset = tbl[i].rst; cpu_req_valid = tbl[i].creq; cpu_we = tbl[i].cwe;
            cpu_halt = tbl[i].halt; cpu_addr = '0; cpu_wdata = '0;
            dbg_req_valid = tbl[i].dval; dbg_rw = tbl[i].drw; dbg_mem_type = tbl[i].dtype;
            dbg_addr = tbl[i].daddr; dbg_wdata = tbl[i].dwd; dbg_resp_ready = tbl[i].rrdy;
            cycle();
            chk($sformatf("v%0d_ready", i), s_ready, tbl[i].e_ready);
            chk($sformatf("v%0d_stall", i), s_stall, tbl[i].e_stall);
            chk($sformatf("v%0d_we", i), s_we, tbl[i].e_we);
            chk($sformatf("v%0d_re", i), s_re, tbl[i].e_re);
            chk($sformatf("v%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_rv", i), s_rv, tbl[i].e_rv);
            chk($sformatf("v%0d_iwe", i), s_iwe, tbl[i].e_iwe);
            if (tbl[i].e_rv) chk($sformatf("v%0d_frame", i), s_frame, tbl[i].e_frame);
        end

        seq_forced(0, 0);
        seq_forced(1, 3);
        seq_resp_hold();
        seq_reset();

        hold_dbg = 0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(99) == 0);
            if (!hold_dbg) begin
                dbg_req_valid = ($urandom_range(2) == 0);
                dbg_rw = 1'($urandom); dbg_mem_type = ($urandom_range(3) == 0);
                dbg_addr = 9'($urandom); dbg_wdata = $urandom;
            end
            if (!m_last_stall) begin
                cpu_req_valid = ($urandom_range(3) != 0); cpu_we = 1'($urandom);
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if ($urandom_range(15) == 0) cpu_halt = ~cpu_halt;
            dbg_resp_ready = ($urandom_range(2) == 0);
            cycle();
            hold_dbg = dbg_req_valid && !m_last_ready && !reset;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and the UART debug channel (debug port).
- Accepts one debug request at a time and grants it when the CPU port is idle, the core is halted, or the debug request has waited too long. A forced grant stalls the CPU for one cycle.
- Debug requests that target instruction memory go to a dedicated imem debug port. They are allowed only while the core is halted.
- Read results and errors return to the UART as 42-bit frames.

Parameters:
- MAX_WAIT, 8: max cycles a latched debug request waits before a forced grant (1..255).
- DADDR_W, 9: debug word-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req_valid  in  1  MEM stage accesses dmem this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data (combinational from mem_rdata).
- cpu_stall  out  1  CPU must hold its MEM access this cycle.
- cpu_halt  in  1  core halted; debug has priority.
- dbg_req_valid  in  1  debug request present.
- dbg_req_ready  out  1  arbiter accepts the debug request.
- dbg_rw  in  1  1 = write, 0 = read.
- dbg_mem_type  in  1  0 = data mem, 1 = instr mem.
- dbg_addr  in  DADDR_W  debug word address.
- dbg_wdata  in  32  debug write data.
- dbg_resp_valid  out  1  response frame valid.
- dbg_resp_ready  in  1  UART TX consumed the frame.
- dbg_resp_frame  out  42  response: {err, addr[8:0], data[31:0]}.
- mem_we, mem_re  out  1 each  data memory write and read enables.
- mem_addr  out  32  data memory byte address.
- mem_wdata  out  32  data memory write data.
- mem_rdata  in  32  combinational read data.
- imem_dbg_we  out  1  instruction memory debug write enable.
- imem_dbg_addr  out  DADDR_W  instruction memory debug word address.
- imem_dbg_wdata  out  32  instruction memory debug write data.
- imem_dbg_rdata  in  32  combinational instruction memory read data.

Behaviour:
- Reset (synchronous): state = IDLE, wait_cnt = 0, request and response registers = 0.
  - All outputs are 0 except CPU pass-through.
  - dbg_req_ready = 0 while reset is high.
  - Reset mid-operation aborts the request silently; no frame is produced.
- States:
  - IDLE: dbg_req_ready = 1. On dbg_req_valid, latch rw/type/addr/wdata, clear wait_cnt, go to ARB.
  - ARB, dbg_mem_type = 0:
    - grant = !cpu_req_valid | cpu_halt | (wait_cnt == MAX_WAIT).
    - On grant:
      - mem_addr = {addr, 2'b00}; mem_we = rw; mem_re = !rw; mem_wdata = latched wdata.
      - cpu_stall = cpu_req_valid; CPU-side mem_we/mem_re are suppressed.
      - A read captures mem_rdata into frame {0, addr, data} and goes to RESP.
      - A write goes to IDLE with no frame.
    - Without grant: wait_cnt increments (saturating), CPU passes through, cpu_stall = 0.
  - ARB, dbg_mem_type = 1:
    - If cpu_halt: a write pulses imem_dbg_we for 1 cycle and goes to IDLE; a read captures imem_dbg_rdata into the frame and goes to RESP.
    - If not cpu_halt: the frame is {1, addr, 32'h0} and the state goes to RESP (writes also get this error frame).
  - RESP: dbg_resp_valid = 1; the frame is held stable. On dbg_resp_ready, go to IDLE.
- CPU pass-through (every cycle without a debug grant):
  - mem_we = cpu_req_valid & cpu_we; mem_re = cpu_req_valid & !cpu_we.
  - mem_addr = cpu_addr; mem_wdata = cpu_wdata.
- cpu_rdata = mem_rdata when the CPU is granted, else 0.
- Timing: the grant cycle lasts exactly 1 cycle. Minimum latency from accept to resp_valid is 2 cycles (IDLE→ARB→RESP).
- cpu_stall is asserted only in the forced-grant cycle. A CPU store is never lost: it is held by the stall and replayed the next cycle.
- Simultaneous events:
  - cpu_halt rising while in ARB grants immediately.
  - dbg_req_valid in RESP is not accepted (ready = 0).
- Requests are never dropped; the debug side must hold its fields while valid & !ready.

Test Plan:
- Debug write of addr 0x005, data 0xDEADBEEF, with the CPU idle → next cycle mem_we = 1, mem_addr = 0x14, no frame, back to IDLE; a debug read of 0x005 then returns frame {0, 0x005, 0xDEADBEEF}.
- CPU issues stores every cycle and a debug read of addr 0x003 is latched with MAX_WAIT = 8 → 8 cycles of pass-through, then exactly one cycle with cpu_stall = 1 and mem_re = 1, mem_addr = 0x0C; the CPU store is written the following cycle.
- Same as the previous scenario with cpu_halt asserted mid-wait → grant in the same cycle halt is seen; wait_cnt does not reach 8.
- Instruction-memory write (type 1, addr 0x010, data 0x00000013) with cpu_halt = 0 → frame {1, 0x010, 0}, imem_dbg_we stays 0; with cpu_halt = 1 → imem_dbg_we pulses once and no frame is produced.
- dbg_resp_ready held low for 5 cycles in RESP → frame stable, dbg_req_ready = 0, new request not accepted until the cycle after ready.
- Reset asserted in ARB and RESP → next cycle IDLE, dbg_resp_valid = 0, no memory write issued.
